// File: rtl/capture_event_arbiter_if.sv
// Event handshake between the capture arbiter (master) and its consumer (slave).
// evt_time exists only when CAPTURE_ARB_TIMESTAMP_EN is defined.
interface capture_event_arbiter_if #(
    parameter int IDX_WIDTH = 4
);
    logic                 evt_valid;
    logic                 evt_ready;
    logic [IDX_WIDTH-1:0] evt_port;
`ifdef CAPTURE_ARB_TIMESTAMP_EN
    logic [15:0]          evt_time;

    modport master (output evt_valid, output evt_port, output evt_time, input evt_ready);
    modport slave  (input evt_valid, input evt_port, input evt_time, output evt_ready);
`else
    modport master (output evt_valid, output evt_port, input evt_ready);
    modport slave  (input evt_valid, input evt_port, output evt_ready);
`endif
endinterface

// File: rtl/capture_event_arbiter.sv
// Round-robin arbiter turning sticky per-port capture flags into a valid/ready event stream.
// Define CAPTURE_ARB_TIMESTAMP_EN to add a free-running timestamp latched with each grant.
module capture_event_arbiter #(
    parameter int NUM_PORTS = 12,
    parameter int IDX_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_PORTS-1:0]    capture,
    output logic [NUM_PORTS-1:0]    clr,
    output logic                    irq,
    output logic                    err,
    input  logic                    err_clr,
    capture_event_arbiter_if.master evt
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        CLEAR,
        WAIT
    } state_t;

    state_t               state;
    logic                 evt_valid_q;
    logic [IDX_WIDTH-1:0] evt_port_q;
    logic [IDX_WIDTH-1:0] ptr;
    logic [IDX_WIDTH-1:0] winner;
    logic [IDX_WIDTH-1:0] idx;
    logic [3:0]           timeout;
    logic [3:0]           timeout_next;
    logic                 any_capture;
    logic                 port_pending;
    logic                 grant;

    assign any_capture  = |capture;
    assign port_pending = capture[evt_port_q];
    assign grant        = (state == IDLE) && enable && any_capture;
    assign timeout_next = timeout + 4'd1;

    // Scan from farthest to nearest so the first set bit after ptr overwrites the rest.
    always_comb begin
        int j;
        j      = 0;
        idx    = '0;
        winner = ptr;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            idx = IDX_WIDTH'(j);
            if (capture[idx]) begin
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            evt_valid_q <= 1'b0;
            evt_port_q  <= '0;
            clr         <= '0;
            irq         <= 1'b0;
            err         <= 1'b0;
            timeout     <= '0;
            ptr         <= IDX_WIDTH'(NUM_PORTS - 1);
        end else begin
            irq <= enable & any_capture;
            clr <= '0;
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (grant) begin
                        evt_port_q  <= winner;
                        evt_valid_q <= 1'b1;
                        state       <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (evt.evt_ready) begin
                        evt_valid_q <= 1'b0;
                        clr         <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << evt_port_q;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    timeout <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // A flag that refuses to clear must not wedge the arbiter; flag it and move on.
                    if (!port_pending) begin
                        ptr     <= evt_port_q;
                        timeout <= '0;
                        state   <= IDLE;
                    end else if (timeout_next == 4'd15) begin
                        err     <= 1'b1;
                        ptr     <= evt_port_q;
                        timeout <= '0;
                        state   <= IDLE;
                    end else begin
                        timeout <= timeout_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_port  = evt_port_q;

`ifdef CAPTURE_ARB_TIMESTAMP_EN
    logic [15:0] ts_count;
    logic [15:0] evt_time_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_count   <= '0;
            evt_time_q <= '0;
        end else begin
            if (enable) begin
                ts_count <= ts_count + 16'd1;
            end
            if (grant) begin
                evt_time_q <= ts_count;
            end
        end
    end

    assign evt.evt_time = evt_time_q;
`endif

endmodule

// File: tb/tb_capture_event_arbiter.sv
// Self-checking bench for capture_event_arbiter: grant-order vector table plus hand sequences
// for stall, enable gating, clear timeout, mid-transaction reset and (optionally) timestamps.
module tb_capture_event_arbiter;

    localparam int NUM_PORTS = 12;
    localparam int IDX_WIDTH = 4;

    typedef struct packed {
        logic [11:0] cap;
        logic [3:0]  n;
        logic [47:0] seq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] capture;
    logic [11:0] clr;
    logic        irq;
    logic        err;
    logic        err_clr;
    logic [11:0] stuck_mask;

    int tests  = 0;
    int failed = 0;

    logic [3:0] exp_q[$];
    logic       hold_pending = 1'b0;
    logic [3:0] held_port    = 4'd0;
    logic       clr_expected = 1'b0;
    logic [3:0] last_port    = 4'd0;

    capture_event_arbiter_if #(.IDX_WIDTH(IDX_WIDTH)) evt_if ();

    capture_event_arbiter #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_WIDTH(IDX_WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .capture(capture),
        .clr    (clr),
        .irq    (irq),
        .err    (err),
        .err_clr(err_clr),
        .evt    (evt_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        failed++;
        $display("[TB] FAIL %s: wait budget expired", name);
    endtask

    task automatic applyStimulus(input logic [11:0] cap, input logic rdy, input logic en);
        @(posedge clk);
        #1;
        capture          = cap;
        evt_if.evt_ready = rdy;
        enable           = en;
    endtask

    // One negedge step: scoreboard on handshakes, clr pulse and hold checks, plus the I/O block's flag clearing.
    task automatic tick();
        logic [3:0]  expected_port;
        logic [11:0] expected_clr;
        @(negedge clk);
        if (!rst_n) begin
            hold_pending = 1'b0;
            clr_expected = 1'b0;
            return;
        end
        if (hold_pending) begin
            checkOutput("valid_hold", 32'({evt_if.evt_valid, evt_if.evt_port}), 32'({1'b1, held_port}));
        end
        expected_clr = 12'd1 << last_port;
        if (clr_expected) begin
            checkOutput("clr_pulse", 32'(clr), 32'(expected_clr));
        end else if (clr != 12'd0) begin
            checkOutput("clr_spurious", 32'(clr), 32'h0);
        end
        clr_expected = 1'b0;
        if (evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("[TB] FAIL unexpected_grant: got port %0d, expected no grant", evt_if.evt_port);
            end else begin
                expected_port = exp_q.pop_front();
                checkOutput("grant_port", 32'(evt_if.evt_port), 32'(expected_port));
            end
            last_port    = evt_if.evt_port;
            clr_expected = 1'b1;
        end
        hold_pending = evt_if.evt_valid && !evt_if.evt_ready;
        held_port    = evt_if.evt_port;
        if (clr != 12'd0) begin
            capture = capture & ~(clr & ~stuck_mask);
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (!(capture == 12'd0 && !evt_if.evt_valid && clr == 12'd0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            reportTimeout(name);
        end
        repeat (3) tick();
        checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        int   n;

        vecs[0] = '{12'h821, 4'd3,  48'h0000_0000_0B50};
        vecs[1] = '{12'h001, 4'd1,  48'h0000_0000_0000};
        vecs[2] = '{12'h003, 4'd2,  48'h0000_0000_0001};
        vecs[3] = '{12'hFFF, 4'd12, 48'h0BA9_8765_4321};
        vecs[4] = '{12'h400, 4'd1,  48'h0000_0000_000A};
        vecs[5] = '{12'h801, 4'd2,  48'h0000_0000_000B};
        vecs[6] = '{12'h090, 4'd2,  48'h0000_0000_0074};
        vecs[7] = '{12'h044, 4'd2,  48'h0000_0000_0062};

        rst_n            = 1'b1;
        enable           = 1'b0;
        capture          = '0;
        err_clr          = 1'b0;
        stuck_mask       = '0;
        evt_if.evt_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_valid", 32'(evt_if.evt_valid), 32'h0);
        checkOutput("reset_port",  32'(evt_if.evt_port),  32'h0);
        checkOutput("reset_clr",   32'(clr),              32'h0);
        checkOutput("reset_irq",   32'(irq),              32'h0);
        checkOutput("reset_err",   32'(err),              32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single capture on port 0: one-cycle grant latency, one clr pulse, irq follows capture.
        exp_q.push_back(4'd0);
        applyStimulus(12'h001, 1'b1, 1'b1);
        tick();
        checkOutput("basic_no_early_valid", 32'(evt_if.evt_valid), 32'h0);
        tick();
        checkOutput("basic_valid_port_irq", 32'({evt_if.evt_valid, evt_if.evt_port, irq}), 32'({1'b1, 4'd0, 1'b1}));
        tick();
        checkOutput("basic_clr_cycle", 32'({evt_if.evt_valid, clr}), 32'({1'b0, 12'h001}));
        tick();
        checkOutput("basic_after_clr", 32'({clr, irq}), 32'h0);
        waitIdle("basic", 50);

        // Consumer stalls for ten cycles.
        exp_q.push_back(4'd4);
        applyStimulus(12'h010, 1'b0, 1'b1);
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            checkOutput("stall_hold", 32'({evt_if.evt_valid, evt_if.evt_port, clr}), 32'({1'b1, 4'd4, 12'h000}));
            tick();
        end
        applyStimulus(12'h010, 1'b1, 1'b1);
        waitIdle("stall_release", 50);

        // Dropping enable mid-transaction lets it finish but blocks the next grant.
        exp_q.push_back(4'd1);
        applyStimulus(12'h002, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(12'h002, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("disabled_inflight", 32'({evt_if.evt_valid, irq}), 32'({1'b1, 1'b0}));
        applyStimulus(12'h002, 1'b1, 1'b0);
        waitIdle("disabled_complete", 50);
        applyStimulus(12'h004, 1'b1, 1'b0);
        repeat (6) tick();
        checkOutput("disabled_no_grant", 32'({evt_if.evt_valid, irq}), 32'h0);
        exp_q.push_back(4'd2);
        applyStimulus(12'h004, 1'b1, 1'b1);
        waitIdle("reenabled", 50);

        // Port 3 flag stuck after clr: timeout, err, then re-grant once the flag clears.
        stuck_mask = 12'h008;
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd3);
        applyStimulus(12'h008, 1'b1, 1'b1);
        n = 0;
        while (clr == 12'd0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            reportTimeout("stuck_clr_wait");
        end
        n = 0;
        while (!err && n < 50) begin
            tick();
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'd16);
        stuck_mask = '0;
        waitIdle("stuck_regrant", 100);
        checkOutput("err_sticky", 32'(err), 32'h1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        tick();
        @(posedge clk);
        #1 err_clr = 1'b0;
        tick();
        checkOutput("err_cleared", 32'(err), 32'h0);

        // Reset while presenting: outputs drop at once, no clr, same port granted again afterwards.
        exp_q.push_back(4'd5);
        applyStimulus(12'h020, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("pre_reset_present", 32'({evt_if.evt_valid, evt_if.evt_port}), 32'({1'b1, 4'd5}));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 32'({evt_if.evt_valid, evt_if.evt_port, clr, irq, err}), 32'h0);
        tick();
        rst_n = 1'b1;
        applyStimulus(12'h020, 1'b1, 1'b1);
        waitIdle("reset_regrant", 50);

        // Grant-order table from a fresh reset (pointer starts before port 0).
        tick();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                exp_q.push_back(vecs[v].seq[k*4 +: 4]);
            end
            applyStimulus(vecs[v].cap, 1'b1, 1'b1);
            waitIdle($sformatf("vec%0d", v), 300);
            checkOutput($sformatf("vec%0d_irq", v), 32'(irq), 32'h0);
        end

`ifdef CAPTURE_ARB_TIMESTAMP_EN
        // Timestamp wraps: 0x1_0005 enabled cycles before the grant leaves 0x0005.
        enable = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(12'h000, 1'b1, 1'b1);
        repeat (32'h1_0005) tick();
        exp_q.push_back(4'd0);
        applyStimulus(12'h001, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("evt_time_wrap", 32'(evt_if.evt_time), 32'h0005);
        waitIdle("timestamp", 50);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/capture_event_arbiter.md
CAPTURE_EVENT_ARBITER -- requirements
Module: capture_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 12, meaning the number of capture inputs (2..16).
REQ-002 SHALL have parameter IDX_WIDTH, default 4, meaning the width of the port index (ceil(log2(NUM_PORTS))).
REQ-003 SHALL have port clk  in  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port enable  in  1  meaning a global grant enable.
REQ-006 SHALL have port capture  in  NUM_PORTS  meaning the per-port sticky capture flags from the I/O data block.
REQ-007 SHALL have port clr  out  NUM_PORTS  meaning the per-port capture clear, a one-cycle pulse.
REQ-008 SHALL have port evt_valid  out  1  meaning an event is presented.
REQ-009 SHALL have port evt_ready  in  1  meaning the consumer accepts the event.
REQ-010 SHALL have port evt_port  out  IDX_WIDTH  meaning the index of the presented port.
REQ-011 SHALL have port irq  out  1  meaning registered: enable AND any capture pending.
REQ-012 SHALL have port err  out  1  meaning sticky clear-timeout error.
REQ-013 SHALL have port err_clr  in  1  meaning clears err.

Function
REQ-014 SHALL implement FSM states IDLE, PRESENT, CLEAR and WAIT.
REQ-015 SHALL, in IDLE with enable=1 and capture!=0, latch the round-robin winner into evt_port and go to PRESENT; evt_valid rises the cycle after capture is first sampled (1-cycle latency).
REQ-016 SHALL start the round-robin search at ptr+1, wrapping NUM_PORTS-1 -> 0, and grant the first set bit found.
REQ-017 SHALL, in PRESENT, hold evt_valid=1 and keep evt_port stable until evt_ready=1, then go to CLEAR; evt_valid SHALL never drop without a handshake.
REQ-018 SHALL, in CLEAR, drive clr[evt_port]=1 for exactly one cycle (all other clr bits 0), deassert evt_valid, and go to WAIT.
REQ-019 SHALL, in WAIT, set ptr=evt_port and go to IDLE when capture[evt_port]=0; otherwise increment a 4-bit timeout counter.
REQ-020 SHALL, when the timeout counter reaches 15 in WAIT, set err=1, update ptr, and go to IDLE.
REQ-021 SHALL, when enable=0, block new grants in IDLE only; an in-flight transaction SHALL complete normally.
REQ-022 SHALL give simultaneous err_clr and a new timeout priority to set (err=1).
REQ-023 SHALL ignore captures on non-granted ports during a transaction; they remain pending for later rounds.
REQ-024 SHALL only compute irq, with 1-cycle latency, and SHALL not gate irq on FSM state.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force: state IDLE, evt_valid=0, evt_port=0, clr=0, irq=0, err=0, timeout=0, ptr=NUM_PORTS-1 (so the first search starts at port 0).
REQ-026 SHALL, when reset asserts mid-transaction, abort that transaction with no clr pulse; the capture stays pending and is re-granted after reset.

Configuration
REQ-027 SHALL, with macro CAPTURE_ARB_TIMESTAMP_EN defined, add a 16-bit free-running counter (increments every cycle while enable=1, wraps 0xFFFF->0, reset 0) and an output evt_time[15:0] latched at grant and stable through PRESENT.
REQ-028 SHALL, without CAPTURE_ARB_TIMESTAMP_EN, have neither the evt_time port nor the counter; all other behaviour is identical.

Verification
REQ-029 SHALL be covered by: after reset, capture=0x001, evt_ready=1 -> evt_valid one cycle later, evt_port=0, clr=0x001 for one cycle, irq=1 then 0.
REQ-030 SHALL be covered by: capture=0x821 held, captures clear on clr -> grant order 0, 5, 11, with no repeat before wrap.
REQ-031 SHALL be covered by: evt_ready=0 for 10 cycles -> evt_valid and evt_port stable for 10 cycles, no clr until the handshake.
REQ-032 SHALL be covered by: capture[3] stuck high after clr -> err=1 after 15 WAIT cycles, port 3 re-granted; err_clr -> err=0.
REQ-033 SHALL be covered by: rst_n pulsed low in PRESENT -> all outputs 0 immediately; after release the same port is re-granted.
REQ-034 SHALL be covered by: with CAPTURE_ARB_TIMESTAMP_EN, enable held 0x1_0005 cycles then grant -> evt_time=0x0005 (wrap checked).
